// File: rtl/inst_loader_pkg.sv
// Shared constants for the instruction RAM loader: FSM encoding and
// word/byte geometry used by both the loader and the RAM address shift.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = 2;
    localparam int BYTE_CNT_W     = 2;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input handshake plus instruction RAM write port, grouped as
// one bundle between the loader (master) and its surroundings (slave).
interface inst_loader_if #(
    parameter int W = 32
) ();

    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         is_write;
    logic [W-1:0] im_addr;
    logic [W-1:0] im_inst;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output is_write,
        output im_addr,
        output im_inst
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  is_write,
        input  im_addr,
        input  im_inst
    );

endinterface

// File: rtl/inst_loader_byte_assembler.sv
// Packs accepted bytes little-endian into a word; word_valid marks the
// accept that completes a word, with word_next holding that complete word.
module inst_loader_byte_assembler
    import inst_loader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         byte_en,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] word_next,
    output logic         word_valid
);

    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]          shift_q, shift_d;

    // New bytes enter at the top so byte 0 ends up in bits [7:0] after four shifts.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d = '0;
        end else if (byte_en) begin
            shift_d = {byte_in, shift_q[W-1:8]};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_next  = shift_d;
    assign word_valid = byte_en && !clear && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_loader.sv
// Instruction RAM loader: reads a word count then that many little-endian
// words from a byte stream and writes them to consecutive RAM addresses.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int w         = 32,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 2057
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    inst_loader_if.master bus,
    output logic          core_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [w-1:0] BASE  = w'(BASE_ADDR);
    localparam logic [w-1:0] MAX_W = w'(MAX_WORDS);

    state_t         state_q, state_d;
    logic [w-1:0]   count_q, count_d;
    logic [w-1:0]   index_q, index_d;
    logic [w-1:0]   index_next;
    logic           err_q, err_d;
    logic [w-1:0]   im_addr_q, im_addr_d;
    logic [w-1:0]   im_inst_q, im_inst_d;

    logic           rx_ready;
    logic           byte_en;
    logic           start_ok;
    logic [w-1:0]   word_next;
    logic           word_valid;

    assign rx_ready   = (state_q == LEN) || (state_q == DATA);
    assign byte_en    = bus.rx_valid && rx_ready;
    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
    assign index_next = index_q + 1'b1;

    inst_loader_byte_assembler #(
        .W (w)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_en    (byte_en),
        .byte_in    (bus.rx_data),
        .word_next  (word_next),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        err_d     = err_q;
        im_addr_d = im_addr_q;
        im_inst_d = im_inst_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LEN;
                    err_d   = 1'b0;
                    index_d = '0;
                    count_d = '0;
                end
            end
            LEN: begin
                if (word_valid) begin
                    count_d = word_next;
                    if (word_next == '0) begin
                        state_d = DONE;
                    end else begin
                        if (word_next > MAX_W) begin
                            err_d = 1'b1;
                        end
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // Address/data are latched here so they are stable for the whole WRITE cycle.
                if (word_valid) begin
                    im_inst_d = word_next;
                    im_addr_d = BASE + (index_q << WORD_SHIFT);
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                index_d = index_next;
                state_d = (index_next == count_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            index_q   <= '0;
            err_q     <= 1'b0;
            im_addr_q <= '0;
            im_inst_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            err_q     <= err_d;
            im_addr_q <= im_addr_d;
            im_inst_q <= im_inst_d;
        end
    end

    // Words past the RAM depth are still framed but never strobed.
    assign bus.is_write = (state_q == WRITE) && (index_q < MAX_W);
    assign bus.rx_ready = rx_ready;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_inst  = im_inst_q;
    assign busy         = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE);
    assign core_hold    = busy;
    assign done         = (state_q == DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table of program loads plus
// hand-written reset and start-corner sequences, with a write scoreboard.
module tb_inst_loader;

    localparam int          MAXW = 2057;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } wr_t;

    typedef struct {
        int          n;
        bit          toggle;
        logic [31:0] w0;
        bit          poke;
        bit          exp_err;
        int          exp_wr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic core_hold, busy, done, err;

    inst_loader_if #(.W(32)) bus ();

    inst_loader #(
        .w         (32),
        .BASE_ADDR (0),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_wr = 0;
    int          wr_cnt = 0;
    bit          spacing_en = 1'b0;
    bit          stalled = 1'b0;
    wr_t         sb[$];
    logic [31:0] ram [logic [31:0]];
    vec_t        vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gen(input logic [31:0] w0, input int i);
        return (i == 0) ? w0 : (w0 ^ (32'(i) * 32'h9E3779B9));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: models the RAM and pops the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (bus.is_write === 1'b1) begin
            if (spacing_en && wr_cnt > 0) check("wr_spacing", 32'(cyc - last_wr), 32'd5);
            last_wr = cyc;
            wr_cnt++;
            ram[bus.im_addr] = bus.im_inst;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h inst %0h expected no write", bus.im_addr, bus.im_inst);
            end else begin
                e = sb.pop_front();
                check("wr_addr", bus.im_addr, e.addr);
                check("wr_inst", bus.im_inst, e.inst);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int t = 0;
        if (stalled) return;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            stalled = 1'b1;
            check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
            return;
        end
        @(posedge clk); #1;
        if (toggle) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'hA5;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] wd, input bit toggle);
        for (int k = 0; k < 4; k++) send_byte(wd[8*k +: 8], toggle);
    endtask

    task automatic run_load(input vec_t v);
        logic [31:0] wd;
        int          t;
        wr_cnt     = 0;
        stalled    = 1'b0;
        spacing_en = !v.toggle && !v.poke;
        pulse_start();
        check("start_done_clr", 32'(done), 32'd0);
        check("start_err_clr", 32'(err), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold", 32'(core_hold), 32'd1);
        send_word(32'(v.n), v.toggle);
        for (int i = 0; i < v.n; i++) begin
            wd = gen(v.w0, i);
            if (i < MAXW) sb.push_back('{BASE + 32'(i) * 32'd4, wd});
            for (int k = 0; k < 4; k++) begin
                if (v.poke && i == 0 && k == 2) begin
                    bus.rx_valid = 1'b0;
                    pulse_start();
                end
                send_byte(wd[8*k +: 8], v.toggle);
            end
        end
        bus.rx_valid = 1'b0;
        t = 0;
        while (done !== 1'b1 && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        check("end_done", 32'(done), 32'd1);
        check("end_hold", 32'(core_hold), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("end_err", 32'(err), 32'(v.exp_err));
        check("end_wr_cnt", 32'(wr_cnt), 32'(v.exp_wr));
        check("end_sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        for (int i = 0; i < v.n && i < 3; i++) begin
            wd = BASE + 32'(i) * 32'd4;
            check("ram_readback", ram.exists(wd) ? ram[wd] : 32'hxxxxxxxx, gen(v.w0, i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t hv;
        vecs[0] = '{n: 1,        toggle: 0, w0: 32'h00000513, poke: 0, exp_err: 0, exp_wr: 1};
        vecs[1] = '{n: 3,        toggle: 0, w0: 32'h00100093, poke: 0, exp_err: 0, exp_wr: 3};
        vecs[2] = '{n: 2,        toggle: 1, w0: 32'hDEADBEEF, poke: 0, exp_err: 0, exp_wr: 2};
        vecs[3] = '{n: 0,        toggle: 0, w0: 32'h0,        poke: 0, exp_err: 0, exp_wr: 0};
        vecs[4] = '{n: 2,        toggle: 0, w0: 32'h0BADF00D, poke: 1, exp_err: 0, exp_wr: 2};
        vecs[5] = '{n: MAXW + 1, toggle: 0, w0: 32'h12345678, poke: 0, exp_err: 1, exp_wr: MAXW};

        rst          = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1;
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_is_write", 32'(bus.is_write), 32'd0);
        check("rst_hold", 32'(core_hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_im_addr", bus.im_addr, 32'd0);
        check("rst_im_inst", bus.im_inst, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", 32'(core_hold), 32'd0);

        for (int v = 0; v < 6; v++) run_load(vecs[v]);

        // Start from DONE with err set: both clear and the load restarts at BASE.
        hv = '{n: 1, toggle: 0, w0: 32'h00A00093, poke: 0, exp_err: 0, exp_wr: 1};
        run_load(hv);

        // Async reset two bytes into the third word of a 3-word load.
        wr_cnt     = 0;
        spacing_en = 1'b0;
        stalled    = 1'b0;
        pulse_start();
        send_word(32'd3, 1'b0);
        sb.push_back('{BASE, 32'h11223344});
        send_word(32'h11223344, 1'b0);
        sb.push_back('{BASE + 32'd4, 32'h55667788});
        send_word(32'h55667788, 1'b0);
        send_byte(8'h99, 1'b0);
        send_byte(8'hAA, 1'b0);
        check("pre_rst_wr_cnt", 32'(wr_cnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("arst_is_write", 32'(bus.is_write), 32'd0);
        check("arst_hold", 32'(core_hold), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_im_addr", bus.im_addr, 32'd0);
        check("arst_im_inst", bus.im_inst, 32'd0);
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        hv = '{n: 1, toggle: 0, w0: 32'hCAFEF00D, poke: 0, exp_err: 0, exp_wr: 1};
        run_load(hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
